// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and multi-cycle MDU stall controller for the five-stage MIPS pipeline.
// Optional MDU watchdog enabled by defining HAZARD_MDU_TIMEOUT_EN.
module hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             BranchD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MduStartE,
  input  logic             MDUReadyE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduBusy,
  output logic             MduTimeout,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic w_lwstall;
  logic w_branchstall;
  logic w_mdustall;
  logic w_stall;
  logic w_timeout;

  logic [CNT_W-1:0] r_stall_cnt;

  if (MDU_TIMEOUT < 2) begin : g_bad_timeout
    $error("MDU_TIMEOUT must be at least 2");
  end

  // Execute-stage operand forwarding; MEM has priority over WB as it is younger.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM) begin
      ForwardAE = 2'b10;
    end else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW) begin
      ForwardAE = 2'b01;
    end
    if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM) begin
      ForwardBE = 2'b10;
    end else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW) begin
      ForwardBE = 2'b01;
    end
  end

  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

  assign w_lwstall     = MemtoRegE && (RtE == RsD || RtE == RtD);
  assign w_branchstall = BranchD &&
                         ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                          (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));

`ifdef HAZARD_MDU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(MDU_TIMEOUT);

  logic [TW-1:0] r_busy_cnt;
  logic          r_timeout;

  assign w_timeout = (r_state == StBusy) && !MDUReadyE &&
                     (r_busy_cnt == TW'(MDU_TIMEOUT - 1));

  // Held at zero while idle so it reads zero on the first BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_cnt <= '0;
    end else if (r_state == StIdle) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_timeout <= 1'b1;
    end
  end

  assign MduTimeout = r_timeout;
`else
  assign w_timeout  = 1'b0;
  assign MduTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready (or watchdog expiry) releases the stall in the same cycle so EX advances on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_mdustall  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (MduStartE && !MDUReadyE) begin
          w_mdustall  = 1'b1;
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        if (MDUReadyE || w_timeout) begin
          w_state_nxt = StIdle;
        end else begin
          w_mdustall = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_stall = w_lwstall || w_branchstall || w_mdustall;

  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign StallE  = w_mdustall;
  assign FlushE  = (w_lwstall || w_branchstall) && !w_mdustall;
  assign FlushD  = 1'b0;
  assign MduBusy = (r_state == StBusy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != {CNT_W{1'b1}}) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized mix against a
// cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned TO_CYC = 8;
  localparam int unsigned CNT_W  = 32;
`ifdef HAZARD_MDU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic BranchD, RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MduStartE, MDUReadyE;
  logic StallF, StallD, StallE, FlushD, FlushE, ForwardAD, ForwardBD, MduBusy, MduTimeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: op in flight, BUSY cycles already waited, sticky flag, stall total.
  bit     m_busy = 1'b0;
  int     m_wait = 0;
  bit     m_to   = 1'b0;
  longint m_cnt  = 0;

  hazard_ctrl #(.MDU_TIMEOUT(TO_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MduStartE(MduStartE), .MDUReadyE(MDUReadyE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduBusy(MduBusy), .MduTimeout(MduTimeout), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_fwd_e(input logic [4:0] s);
    if (s != 0 && RegWriteM && s == WriteRegM) return 2'b10;
    if (s != 0 && RegWriteW && s == WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_fwd_d(input logic [4:0] s);
    return (s != 0) && RegWriteM && (s == WriteRegM);
  endfunction

  function automatic logic exp_lw();
    return MemtoRegE && (RtE == RsD || RtE == RtD);
  endfunction

  function automatic logic exp_br();
    return BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
  endfunction

  function automatic logic exp_mdu();
    if (!m_busy) return MduStartE && !MDUReadyE;
    if (MDUReadyE) return 1'b0;
    if (TO_EN && m_wait == int'(TO_CYC) - 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_stall();
    return exp_lw() || exp_br() || exp_mdu();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_wait <= 0; m_to <= 1'b0; m_cnt <= 0;
    end else begin
      if (exp_stall() && m_cnt != 64'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      if (!m_busy) begin
        m_busy <= MduStartE && !MDUReadyE;
        m_wait <= 0;
      end else if (MDUReadyE) begin
        m_busy <= 1'b0;
      end else if (TO_EN && m_wait == int'(TO_CYC) - 1) begin
        m_busy <= 1'b0;
        m_to   <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    BranchD = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    MduStartE = 0; MDUReadyE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    n_vec++; if (MduBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", MduBusy); end
    n_vec++; if (MduTimeout !== 1'b0) begin n_err++; $display("FAIL reset_to got=%b exp=0", MduTimeout); end
    n_vec++; if (StallCount !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", StallCount); end
    n_vec++; if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl got=%b exp=00000", {StallF, StallD, StallE, FlushD, FlushE});
    end
    #4;
    rst = 1'b1;
  endtask

  task automatic test_forwarding();
    tick();
    clear_inputs();
    RegWriteM = 1; WriteRegM = 8; RsE = 8;
    #1;
    n_vec++; if (ForwardAE !== 2'b10) begin n_err++; $display("FAIL fwd_mem got=%b exp=10", ForwardAE); end
    RsE = 0;
    #1;
    n_vec++; if (ForwardAE !== 2'b00) begin n_err++; $display("FAIL fwd_r0 got=%b exp=00", ForwardAE); end
    for (int i = 0; i < 40; i++) begin
      tick();
      {RsD, RtD, RsE, RtE} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {WriteRegM, WriteRegW} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {RegWriteM, RegWriteW} = 2'($urandom);
      #1;
      n_vec++; if (ForwardAE !== exp_fwd_e(RsE)) begin
        n_err++; $display("FAIL fwd_ae i=%0d got=%b exp=%b", i, ForwardAE, exp_fwd_e(RsE)); end
      n_vec++; if (ForwardBE !== exp_fwd_e(RtE)) begin
        n_err++; $display("FAIL fwd_be i=%0d got=%b exp=%b", i, ForwardBE, exp_fwd_e(RtE)); end
      n_vec++; if ({ForwardAD, ForwardBD} !== {exp_fwd_d(RsD), exp_fwd_d(RtD)}) begin
        n_err++; $display("FAIL fwd_d i=%0d got=%b%b exp=%b%b", i, ForwardAD, ForwardBD,
                          exp_fwd_d(RsD), exp_fwd_d(RtD)); end
    end
  endtask

  task automatic test_lwstall();
    tick();
    clear_inputs();
    MemtoRegE = 1; RtE = 9; RsD = 9; RtD = 3;
    #1;
    n_vec++; if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
      n_err++; $display("FAIL lw_hit got=%b exp=1110", {StallF, StallD, FlushE, StallE}); end
    tick();
    MemtoRegE = 0; RtE = 0;
    #1;
    n_vec++; if ({StallF, StallD, FlushE} !== 3'b000) begin
      n_err++; $display("FAIL lw_release got=%b exp=000", {StallF, StallD, FlushE}); end
  endtask

  task automatic test_branchstall();
    tick();
    clear_inputs();
    BranchD = 1; RsD = 5; RtD = 7; RegWriteE = 1; WriteRegE = 5;
    #1;
    n_vec++; if ({StallF, StallD, FlushE} !== 3'b111) begin
      n_err++; $display("FAIL br_hit got=%b exp=111", {StallF, StallD, FlushE}); end
    tick();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 5;
    #1;
    n_vec++; if ({StallF, ForwardAD, ForwardBD} !== 3'b010) begin
      n_err++; $display("FAIL br_fwd got=%b exp=010", {StallF, ForwardAD, ForwardBD}); end
  endtask

  task automatic test_mdu_long();
    int n;
    n = TO_EN ? 6 : 32;
    pulse_reset();
    MduStartE = 1;
    for (int i = 0; i < n; i++) begin
      // Overlap a load-use hazard mid-op: E must be held and nothing flushed.
      MemtoRegE = (i == 3); RtE = (i == 3) ? 5'd4 : 5'd0; RsD = (i == 3) ? 5'd4 : 5'd1;
      #1;
      n_vec++; if ({StallF, StallD, StallE, FlushE} !== 4'b1110) begin
        n_err++; $display("FAIL mdu_stall i=%0d got=%b exp=1110", i, {StallF, StallD, StallE, FlushE}); end
      n_vec++; if (MduBusy !== (i > 0)) begin
        n_err++; $display("FAIL mdu_busy i=%0d got=%b exp=%b", i, MduBusy, i > 0); end
      tick();
    end
    MemtoRegE = 0; RtE = 0; RsD = 0; MDUReadyE = 1;
    #1;
    n_vec++; if ({StallF, StallE, MduBusy} !== 3'b001) begin
      n_err++; $display("FAIL mdu_ready got=%b exp=001", {StallF, StallE, MduBusy}); end
    tick();
    MduStartE = 0; MDUReadyE = 0;
    #1;
    n_vec++; if (MduBusy !== 1'b0) begin n_err++; $display("FAIL mdu_idle got=%b exp=0", MduBusy); end
    n_vec++; if (StallCount !== CNT_W'(n)) begin
      n_err++; $display("FAIL mdu_count got=%0d exp=%0d", StallCount, n); end
    n_vec++; if (StallCount !== m_cnt[CNT_W-1:0]) begin
      n_err++; $display("FAIL mdu_model_count got=%0d exp=%0d", StallCount, m_cnt); end
  endtask

  task automatic test_reset_mid_busy();
    pulse_reset();
    MduStartE = 1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    n_vec++; if ({MduBusy, StallE} !== 2'b11) begin
      n_err++; $display("FAIL rmb_pre got=%b exp=11", {MduBusy, StallE}); end
    rst = 1'b0; MduStartE = 0;
    #1;
    n_vec++; if ({MduBusy, StallF, StallD, StallE} !== 4'b0) begin
      n_err++; $display("FAIL rmb_drop got=%b exp=0000", {MduBusy, StallF, StallD, StallE}); end
    n_vec++; if (StallCount !== '0) begin n_err++; $display("FAIL rmb_cnt got=%0d exp=0", StallCount); end
    #2;
    rst = 1'b1;
  endtask

`ifdef HAZARD_MDU_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    MduStartE = 1;
    for (int i = 0; i < int'(TO_CYC); i++) begin
      #1;
      n_vec++; if (StallF !== 1'b1) begin n_err++; $display("FAIL to_stall i=%0d got=%b exp=1", i, StallF); end
      tick();
    end
    #1;
    n_vec++; if ({StallF, MduTimeout} !== 2'b00) begin
      n_err++; $display("FAIL to_release got=%b exp=00", {StallF, MduTimeout}); end
    tick();
    MduStartE = 0;
    #1;
    n_vec++; if ({MduTimeout, MduBusy} !== 2'b10) begin
      n_err++; $display("FAIL to_flag got=%b exp=10", {MduTimeout, MduBusy}); end
    n_vec++; if (StallCount !== CNT_W'(TO_CYC)) begin
      n_err++; $display("FAIL to_count got=%0d exp=%0d", StallCount, TO_CYC); end
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (MduTimeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", MduTimeout); end
  endtask
`endif

  task automatic test_random_mix();
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      tick();
      {RsD, RtD, RsE, RtE} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {WriteRegE, WriteRegM, WriteRegW} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                          5'($urandom_range(0, 3))};
      {RegWriteE, RegWriteM, RegWriteW, MemtoRegM} = 4'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 3) == 0);
      MduStartE = m_busy ? 1'b1 : ($urandom_range(0, 7) == 0);
      MDUReadyE = ($urandom_range(0, 2) == 0);
      #1;
      n_vec++; if ({StallF, StallD} !== {2{exp_stall()}}) begin
        n_err++; $display("FAIL mix_stallfd i=%0d got=%b%b exp=%b", i, StallF, StallD, exp_stall()); end
      n_vec++; if (StallE !== exp_mdu()) begin
        n_err++; $display("FAIL mix_stalle i=%0d got=%b exp=%b", i, StallE, exp_mdu()); end
      n_vec++; if ({FlushE, FlushD} !== {(exp_lw() || exp_br()) && !exp_mdu(), 1'b0}) begin
        n_err++; $display("FAIL mix_flush i=%0d got=%b%b exp=%b0", i, FlushE, FlushD,
                          (exp_lw() || exp_br()) && !exp_mdu()); end
      n_vec++; if ({ForwardAE, ForwardBE} !== {exp_fwd_e(RsE), exp_fwd_e(RtE)}) begin
        n_err++; $display("FAIL mix_fwde i=%0d got=%b/%b exp=%b/%b", i, ForwardAE, ForwardBE,
                          exp_fwd_e(RsE), exp_fwd_e(RtE)); end
      n_vec++; if ({MduBusy, MduTimeout} !== {m_busy, m_to}) begin
        n_err++; $display("FAIL mix_state i=%0d got=%b%b exp=%b%b", i, MduBusy, MduTimeout, m_busy, m_to); end
      n_vec++; if (StallCount !== m_cnt[CNT_W-1:0]) begin
        n_err++; $display("FAIL mix_count i=%0d got=%0d exp=%0d", i, StallCount, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_lwstall();
    test_branchstall();
    test_mdu_long();
    test_reset_mid_busy();
`ifdef HAZARD_MDU_TIMEOUT_EN
    test_timeout();
`endif
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multi-cycle-MDU controller for the five-stage MIPS core. It sits beside the datapath and generates all stall, flush and forwarding selects (StallF/D/E, FlushD/E, ForwardAD/BD, ForwardAE/BE). It also sequences the EX-stage multiply/divide unit: it holds the pipeline until MDUReadyE is seen, and counts stall cycles for performance debug.

## Interface
- MDU_TIMEOUT, 64: maximum number of cycles the FSM waits in BUSY for MDUReadyE (used only with HAZARD_MDU_TIMEOUT_EN).
- CNT_W, 32: width of the stall-cycle counter.

- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- RsD, RtD  input  5  source registers in ID
- BranchD  input  1  branch in ID
- RsE, RtE  input  5  source registers in EX
- WriteRegE, WriteRegM, WriteRegW  input  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  input  1  register-write enable per stage
- MemtoRegE, MemtoRegM  input  1  load in EX / MEM
- MduStartE  input  1  EX holds a mult/div op
- MDUReadyE  input  1  MDU result valid
- StallF, StallD, StallE  output  1  hold the PC / IF_ID / ID_EX registers
- FlushD, FlushE  output  1  clear the IF_ID / ID_EX registers
- ForwardAD, ForwardBD  output  1  branch comparator operand from ResultM
- ForwardAE, ForwardBE  output  2  ALU operand select: 00 register file, 01 WB, 10 MEM
- MduBusy  output  1  FSM in BUSY
- MduTimeout  output  1  sticky timeout flag
- StallCount  output  CNT_W  saturating count of cycles with StallF=1

## Operation
**Forwarding (combinational)**
- ForwardAE = 10 if RsE≠0 & RegWriteM & RsE==WriteRegM.
- Otherwise ForwardAE = 01 if RsE≠0 & RegWriteW & RsE==WriteRegW.
- Otherwise ForwardAE = 00.
- ForwardBE follows the same rules using RtE.
- ForwardAD = RsD≠0 & RegWriteM & RsD==WriteRegM. ForwardBD follows the same rule using RtD.

**Hazard terms**
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & [(RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))].
- mdustall is defined by the MDU FSM below.

**MDU FSM (states IDLE, BUSY)**
- IDLE:
  - MduStartE & !MDUReadyE: mdustall=1; next state BUSY.
  - MduStartE & MDUReadyE (single-cycle op): no stall; stay in IDLE.
- BUSY:
  - mdustall = !MDUReadyE.
  - MDUReadyE=1: next state IDLE. The stall is released in that same cycle, so EX advances on that edge.
- BUSY cycle counter: cleared on entry to BUSY, incremented each cycle spent in BUSY.

**Outputs**
- StallF = StallD = lwstall | branchstall | mdustall.
- StallE = mdustall.
- FlushE = (lwstall | branchstall) & !mdustall. When mdustall is asserted, FlushE is never asserted, so the in-flight MDU op is never killed.
- FlushD = 0. The core uses a branch delay slot.
- StallCount increments on every cycle with StallF=1 and saturates at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the registered state. They are valid in the same cycle.
- MDUReadyE is sampled on the rising edge of clk. The MDU updates it on the falling edge, so it is stable at the rising edge.
- A multi-cycle op with ready asserted N cycles after EX entry gives N stall cycles.
- Reset (rst=0, asynchronous):
  - state = IDLE, MduBusy = 0, MduTimeout = 0, StallCount = 0, BUSY cycle counter = 0.
  - The combinational outputs then depend only on the inputs.
- Reset mid-BUSY: the FSM returns to IDLE immediately and the stall drops.
- Simultaneous lwstall and mdustall: E is held, F/D are held, no flush.
- Register 0 is never forwarded.

## Configuration
- HAZARD_MDU_TIMEOUT_EN defined:
  - When the BUSY counter reaches MDU_TIMEOUT-1 with MDUReadyE still 0, the FSM forces IDLE on the next edge and releases the stall.
  - MduTimeout is set to 1 and stays set until reset.
- Not defined:
  - No timeout counter. BUSY waits indefinitely.
  - MduTimeout is tied to 0.

## Test plan
- RegWriteM=1, WriteRegM=8, RsE=8 -> ForwardAE=10. The same case with RsE=0 -> ForwardAE=00.
- Load in EX with RtE=9, next instruction RsD=9 -> StallF=StallD=FlushE=1 for exactly 1 cycle.
- BranchD=1, RsD=5, RegWriteE=1, WriteRegE=5 -> branchstall for 1 cycle. The next cycle shows ForwardAD=1 from MEM.
- MduStartE=1, MDUReadyE rises 32 cycles later -> StallF/D/E=1 and MduBusy=1 for 32 cycles, FlushE=0 throughout, StallCount=32.
- rst pulled low in cycle 5 of BUSY -> MduBusy=0 and stalls deasserted immediately, StallCount=0.
- With HAZARD_MDU_TIMEOUT_EN and MDU_TIMEOUT=8, MDUReadyE held at 0 -> stall lasts 8 cycles, then MduTimeout=1 and stays set.
